// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   PC_STEP          : byte distance between sequential instructions
//   fetch_state_t    : fetch control state
//   fetch_entry_t    : one buffered instruction with its PC
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer between the fetch stage and decode.
//   clk, rst            : clock, synchronous active-low reset
//   flush               : drop all entries (wins over push/pop)
//   push, push_pc/inst  : enqueue one entry
//   pop                 : dequeue head entry
//   count               : number of valid entries
//   empty               : no valid entry
//   head_pc/head_inst   : head entry, forced to zero when empty
// The parent guarantees no push when full-without-pop and no pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  output logic [3:0]  count,
  output logic        empty,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && rst && !flush) begin
      mem[wr_ptr].pc   <= push_pc;
      mem[wr_ptr].inst <= push_inst;
    end
  end

  assign empty     = (count == 4'd0);
  assign head_pc   = empty ? 32'h0 : mem[rd_ptr].pc;
  assign head_inst = empty ? 32'h0 : mem[rd_ptr].inst;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues ROM reads and buffers fetched
// instructions for decode.
//   clk, rst        : clock, synchronous active-low reset
//   rom_ce/rom_addr : ROM request, address is the current PC
//   rom_inst        : combinational ROM data for rom_addr
//   redirect_valid/redirect_pc : flush buffer and restart at target
//   stall           : suppress new fetches (pops continue)
//   out_valid/out_inst/out_pc/out_ready : decode handshake on buffer head
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [3:0]   count;
  logic         empty;
  logic         run, pop, flush, fetch, full_after_pop;
  logic [1:0]   unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // Gating with rst keeps rom_ce low in a cycle whose edge will reset.
  assign run            = (state == RUN) && rst;
  assign out_valid      = !empty;
  // A full buffer that is being popped still has room for this fetch.
  assign full_after_pop = (count == 4'(FIFO_DEPTH)) && !(out_valid && out_ready);
  assign flush          = run && redirect_valid;
  // Redirect discards the head, so it also suppresses the pop.
  assign pop            = run && !redirect_valid && out_valid && out_ready;
  assign fetch          = run && !redirect_valid && !stall && !full_after_pop;

  assign rom_ce   = fetch;
  assign rom_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
          else if (fetch)      pc <= pc + PC_STEP;  // wraps naturally at 2^32
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fetch),
    .push_pc   (pc),
    .push_inst (rom_inst),
    .pop       (pop),
    .count     (count),
    .empty     (empty),
    .head_pc   (out_pc),
    .head_inst (out_inst)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based model checked every
// cycle, plus directed literal expectations for the key scenarios.
module tb_inst_fetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        rom_ce, out_valid;
  logic [31:0] rom_addr, rom_inst, out_inst, out_pc;

  // Second instance: wrap-around reset PC, free-running.
  logic        rom_ce2, out_valid2;
  logic [31:0] rom_addr2, rom_inst2, out_inst2, out_pc2;
  logic        stall2 = 1'b0, redirect_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [31:0] redirect_pc2 = 32'h0;

  int tests  = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign rom_inst  = rom_word(rom_addr);
  assign rom_inst2 = rom_word(rom_addr2);

  inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .rom_ce(rom_ce2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .stall(stall2),
    .out_valid(out_valid2), .out_inst(out_inst2), .out_pc(out_pc2), .out_ready(out_ready2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  fetch_pkg::fetch_entry_t mq[$];
  logic [31:0] m_pc  = RST_PC;
  bit          m_run = 0;
  bit          m_pop, m_fetch, e_pop, e_ce;

  always @(posedge clk) begin
    if (!rst) begin
      m_run = 0;
      m_pc  = RST_PC;
      mq.delete();
    end else if (!m_run) begin
      m_run = 1;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      m_pop   = (mq.size() != 0) && out_ready;
      m_fetch = !stall && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_fetch) begin
        mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_pop = (mq.size() != 0) && out_ready;
      e_ce  = m_run && rst && !redirect_valid && !stall && ((mq.size() < DEPTH) || e_pop);
      chk("model rom_ce", {31'h0, rom_ce}, {31'h0, e_ce});
      chk("model rom_addr", rom_addr, m_pc);
      chk("model out_valid", {31'h0, out_valid}, {31'h0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("model out_pc", out_pc, mq[0].pc);
        chk("model out_inst", out_inst, mq[0].inst);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (3) tick();
    chk_en = 1;
    chk("reset rom_ce", {31'h0, rom_ce}, 32'h0);
    chk("reset rom_addr", rom_addr, 32'h0);
    chk("reset out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset out_inst", out_inst, 32'h0);
    chk("reset out_pc", out_pc, 32'h0);
    chk("reset rom_addr2", rom_addr2, 32'hFFFF_FFF8);

    // Release reset with decode blocked: two fetches then hold.
    rst = 1'b1;
    tick();  // IDLE -> RUN edge
    chk("first fetch ce", {31'h0, rom_ce}, 32'h1);
    chk("first fetch addr", rom_addr, 32'h0);
    chk("wrap fetch0 addr2", rom_addr2, 32'hFFFF_FFF8);
    chk("wrap fetch0 ce2", {31'h0, rom_ce2}, 32'h1);
    tick();
    chk("second fetch addr", rom_addr, 32'h4);
    chk("latency out_pc", out_pc, 32'h0);
    chk("latency out_inst", out_inst, rom_word(32'h0));
    chk("wrap fetch1 addr2", rom_addr2, 32'hFFFF_FFFC);
    chk("wrap out_pc2", out_pc2, 32'hFFFF_FFF8);
    tick();
    chk("full ce", {31'h0, rom_ce}, 32'h0);
    chk("full addr", rom_addr, 32'h8);
    chk("wrap fetch2 addr2", rom_addr2, 32'h0);
    chk("wrap out_pc2 b", out_pc2, 32'hFFFF_FFFC);
    repeat (2) tick();
    chk("hold ce", {31'h0, rom_ce}, 32'h0);
    chk("hold addr", rom_addr, 32'h8);
    chk("hold out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("push while full popped", {31'h0, rom_ce}, 32'h1);
    tick();
    chk("drain out_pc 4", out_pc, 32'h4);
    tick();
    chk("drain out_pc 8", out_pc, 32'h8);
    repeat (8) tick();

    // Redirect with a full buffer.
    out_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("redirect ce", {31'h0, rom_ce}, 32'h0);
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("post redirect valid", {31'h0, out_valid}, 32'h0);
    chk("post redirect addr", rom_addr, 32'h100);
    chk("post redirect ce", {31'h0, rom_ce}, 32'h1);
    tick();
    chk("redirect target out_pc", out_pc, 32'h100);
    chk("redirect target inst", out_inst, rom_word(32'h100));

    // Stall and redirect together.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk("stall+redirect ce", {31'h0, rom_ce}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("stalled ce", {31'h0, rom_ce}, 32'h0);
    chk("stalled addr", rom_addr, 32'h200);
    tick();
    chk("stalled addr b", rom_addr, 32'h200);
    chk("stalled valid", {31'h0, out_valid}, 32'h0);
    stall = 1'b0;
    tick();
    chk("unstall out_pc", out_pc, 32'h200);

    // Mid-stream reset with a full buffer.
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("post reset valid", {31'h0, out_valid}, 32'h0);
    chk("post reset ce", {31'h0, rom_ce}, 32'h0);
    tick();
    chk("resume ce", {31'h0, rom_ce}, 32'h1);
    chk("resume addr", rom_addr, RST_PC);
    out_ready = 1'b1;

    // Mixed pattern, checked by the model; includes a wrap through zero.
    for (int i = 0; i < 60; i++) begin
      stall          = (i % 7 == 3);
      out_ready      = (i % 5 != 1) && (i % 5 != 2);
      redirect_valid = (i == 20) || (i == 41);
      redirect_pc    = (i == 20) ? 32'hFFFF_FFF6 : 32'h0000_0ABC;
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset; bits [1:0] SHALL be 0.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries; legal values 2 to 8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 rom_ce  output  1  fetch request to instruction ROM; high only in a cycle that performs a fetch.
REQ-006 rom_addr  output  32  byte address presented to ROM; equals current PC.
REQ-007 rom_inst  input  32  combinational ROM data for rom_addr, valid in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump/exception redirect request.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 stall  input  1  pipeline-control hold; suppresses new fetches.
REQ-011 out_valid  output  1  buffer head holds an instruction for decode.
REQ-012 out_inst  output  32  instruction at buffer head.
REQ-013 out_pc  output  32  PC of out_inst.
REQ-014 out_ready  input  1  decode accepts head; transfer when out_valid and out_ready both high.

Function
REQ-015 State machine: IDLE (entered on reset) and RUN; IDLE->RUN on the first clock edge with rst high; RUN is left only by reset.
REQ-016 In IDLE: rom_ce=0, no pushes, no pops, PC holds RESET_PC.
REQ-017 In RUN, a fetch occurs in a cycle when redirect_valid=0, stall=0, and buffer not full-after-pop; a fetch drives rom_ce=1, pushes {PC, rom_inst} at the clock edge, PC <= PC+4.
REQ-018 Full-after-pop: count==FIFO_DEPTH and not (out_valid and out_ready); a full buffer being popped SHALL accept a push in the same cycle.
REQ-019 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no error indication.
REQ-020 Redirect (RUN, redirect_valid=1): buffer flushed (count<=0), PC <= {redirect_pc[31:2],2'b00}, rom_ce=0, no push; priority over stall and over a concurrent pop.
REQ-021 The first fetch at the redirect target SHALL occur in the cycle after the redirect (if stall=0 and buffer empty).
REQ-022 stall=1 without redirect: rom_ce=0, PC and buffer contents hold except pops, which continue normally.
REQ-023 out_inst/out_pc SHALL come from registered buffer storage; no combinational path from rom_inst to out_inst.
REQ-024 Latency: instruction fetched in cycle N SHALL be at out_* in cycle N+1 if the buffer was empty or was popped to empty in cycle N.
REQ-025 Buffer is in-order FIFO; push and pop in one cycle leave count unchanged; pop of empty buffer SHALL not occur (out_valid=0).
REQ-026 No back-to-back fetch of the same PC except after a redirect to that PC.

Reset
REQ-027 While rst=0 at a clock edge: state<=IDLE, PC<=RESET_PC, count<=0, FIFO pointers<=0.
REQ-028 Reset values: rom_ce=0, rom_addr=RESET_PC, out_valid=0, out_inst=32'h0, out_pc=32'h0.
REQ-029 Reset asserted mid-operation SHALL discard buffered instructions and any pending redirect in the same edge.

Structure
REQ-030 Package fetch_pkg SHALL hold: default RESET_PC constant, PC_STEP=4, fetch_state_t enum {IDLE, RUN}, fetch_entry_t struct {pc[31:0], inst[31:0]}.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (parameterised depth, push/pop/flush, count, synchronous active-low rst); PC and state logic stay in inst_fetch.

Verification
REQ-032 Reset release, out_ready=1, no stall: rom_addr sequence 0,4,8,...; out_pc matches one cycle later, out_inst = ROM word.
REQ-033 out_ready=0 for 5 cycles from reset (depth 2): exactly 2 fetches (PC 0,4), rom_ce=0 after, PC holds 8; on out_ready=1 outputs PC 0,4,8 in order, no gaps or duplicates.
REQ-034 redirect_valid with redirect_pc=32'h0000_0103 while buffer holds 2 entries: out_valid=0 next cycle, next fetch at 32'h0000_0100, stale entries never appear.
REQ-035 stall and redirect asserted in same cycle: redirect taken; with stall held next cycle, rom_ce stays 0 and PC = target.
REQ-036 RESET_PC=32'hFFFF_FFF8, free-running: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst=0 for one cycle mid-stream with full buffer: out_valid=0 next cycle, fetching resumes at RESET_PC one cycle after rst returns high.
